// File: rtl/ram_arb_pkg.sv
// Shared types and constants for arbiters guarding small debug RAMs.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WSETUP = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

    localparam logic REQ_JTAG = 1'b0;
    localparam logic REQ_EXT  = 1'b1;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_WIDTH = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time wins.
// Purely combinational, zero latency; grant is one-hot or zero.
module rr_arbiter2 (
    input  logic [1:0] i_elig,
    input  logic       i_rr_ptr,
    output logic [1:0] o_grant
);

    assign o_grant[0] = i_elig[0] & (~i_elig[1] |  i_rr_ptr);
    assign o_grant[1] = i_elig[1] & (~i_elig[0] | ~i_rr_ptr);

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a single-port debug RAM between JTAG (req 0) and the host (req 1); sequences write/read.
// Write: setup + WR_CYCLES pulse; read: RD_WAIT cycles then RESP held until rready.
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int AWIDTH    = $clog2(DEPTH),
    parameter int WR_CYCLES = 1,
    parameter int RD_WAIT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_mode,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [AWIDTH-1:0] r0_addr,
    input  logic [WIDTH-1:0]  r0_wdata,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [WIDTH-1:0]  r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [AWIDTH-1:0] r1_addr,
    input  logic [WIDTH-1:0]  r1_wdata,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [WIDTH-1:0]  r1_rdata,
    output logic              ram_wr,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_din,
    input  logic [WIDTH-1:0]  ram_dout,
    output logic              busy,
    output logic              grant_id
);

    if (WR_CYCLES < 1 || WR_CYCLES > 7) begin : g_bad_wr_cycles
        $error("ram_access_arbiter: WR_CYCLES must be 1..7");
    end
    if (RD_WAIT < 1 || RD_WAIT > 7) begin : g_bad_rd_wait
        $error("ram_access_arbiter: RD_WAIT must be 1..7");
    end

    localparam logic [2:0] WR_LOAD = 3'(WR_CYCLES - 1);
    localparam logic [2:0] RD_LOAD = 3'(RD_WAIT - 1);

    arb_state_t        r_state;
    logic [2:0]        r_cnt;
    logic              r_rr;
    logic              r_grant;
    logic [AWIDTH-1:0] r_addr;
    logic [WIDTH-1:0]  r_din;
    logic [WIDTH-1:0]  r_rdata0;
    logic [WIDTH-1:0]  r_rdata1;

    logic              w_idle;
    logic [1:0]        w_elig;
    logic [1:0]        w_gnt;
    logic              w_sel;
    logic              w_sel_we;
    logic              w_rready;

    assign w_idle = (r_state == IDLE);
    // test_mode only matters here; an access already granted to the host runs to completion.
    assign w_elig = {r1_valid & ~test_mode, r0_valid};

    rr_arbiter2 u_rr (
        .i_elig   (w_elig),
        .i_rr_ptr (r_rr),
        .o_grant  (w_gnt)
    );

    assign w_sel    = w_gnt[1] ? REQ_EXT : REQ_JTAG;
    assign w_sel_we = w_gnt[1] ? r1_we : r0_we;
    assign w_rready = (r_grant == REQ_EXT) ? r1_rready : r0_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 3'd0;
            r_rr     <= REQ_JTAG;
            r_grant  <= REQ_JTAG;
            r_addr   <= '0;
            r_din    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_addr  <= (w_sel == REQ_EXT) ? r1_addr  : r0_addr;
                        r_din   <= (w_sel == REQ_EXT) ? r1_wdata : r0_wdata;
                        r_grant <= w_sel;
                        r_rr    <= w_sel;
                        r_state <= w_sel_we ? WSETUP : READ;
                        r_cnt   <= w_sel_we ? 3'd0 : RD_LOAD;
                    end
                end
                WSETUP: begin
                    r_state <= WRITE;
                    r_cnt   <= WR_LOAD;
                end
                WRITE: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                READ: begin
                    if (r_cnt == 3'd0) begin
                        if (r_grant == REQ_EXT) r_rdata1 <= ram_dout;
                        else                    r_rdata0 <= ram_dout;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (w_rready) begin
                        r_state <= IDLE;
                        r_cnt   <= 3'd0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign r0_ready  = w_idle & w_gnt[0];
    assign r1_ready  = w_idle & w_gnt[1];
    assign r0_rvalid = (r_state == RESP) & (r_grant == REQ_JTAG);
    assign r1_rvalid = (r_state == RESP) & (r_grant == REQ_EXT);
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;
    // Strobe decoded straight from state so an async reset drops it without a clock edge.
    assign ram_wr    = (r_state == WRITE);
    assign ram_addr  = r_addr;
    assign ram_din   = r_din;
    assign busy      = ~w_idle;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Three arbiter configurations driven with shared stimulus, each checked every cycle
// against a transaction-timeline model (cycles elapsed since accept) plus directed checks.
module tb_ram_access_arbiter;

    localparam int NC = 3;
    localparam int WRC [NC] = '{1, 4, 2};
    localparam int RDW [NC] = '{1, 1, 3};

    logic       clk;
    logic       rst;
    logic       test_mode;
    logic       r0_valid, r0_we, r0_rready;
    logic [1:0] r0_addr, r0_wdata;
    logic       r1_valid, r1_we, r1_rready;
    logic [1:0] r1_addr, r1_wdata;

    logic       r0_ready_o [NC];
    logic       r1_ready_o [NC];
    logic       r0_rvalid_o[NC];
    logic       r1_rvalid_o[NC];
    logic [1:0] r0_rdata_o [NC];
    logic [1:0] r1_rdata_o [NC];
    logic       ram_wr_o   [NC];
    logic [1:0] ram_addr_o [NC];
    logic [1:0] ram_din_o  [NC];
    logic [1:0] ram_dout_i [NC];
    logic       busy_o     [NC];
    logic       grant_o    [NC];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        logic [1:0] mem [4];
        initial for (int i = 0; i < 4; i++) mem[i] = 2'(i);
        always @(posedge clk) if (ram_wr_o[g]) mem[ram_addr_o[g]] <= ram_din_o[g];
        assign ram_dout_i[g] = mem[ram_addr_o[g]];

        ram_access_arbiter #(.WR_CYCLES(WRC[g]), .RD_WAIT(RDW[g])) dut (
            .clk       (clk),
            .rst       (rst),
            .test_mode (test_mode),
            .r0_valid  (r0_valid),
            .r0_ready  (r0_ready_o[g]),
            .r0_we     (r0_we),
            .r0_addr   (r0_addr),
            .r0_wdata  (r0_wdata),
            .r0_rvalid (r0_rvalid_o[g]),
            .r0_rready (r0_rready),
            .r0_rdata  (r0_rdata_o[g]),
            .r1_valid  (r1_valid),
            .r1_ready  (r1_ready_o[g]),
            .r1_we     (r1_we),
            .r1_addr   (r1_addr),
            .r1_wdata  (r1_wdata),
            .r1_rvalid (r1_rvalid_o[g]),
            .r1_rready (r1_rready),
            .r1_rdata  (r1_rdata_o[g]),
            .ram_wr    (ram_wr_o[g]),
            .ram_addr  (ram_addr_o[g]),
            .ram_din   (ram_din_o[g]),
            .ram_dout  (ram_dout_i[g]),
            .busy      (busy_o[g]),
            .grant_id  (grant_o[g])
        );
    end

    // Model: an access is a timeline; t counts cycles since its accept cycle.
    bit         m_busy [NC];
    bit         m_wr   [NC];
    bit         m_own  [NC];
    bit         m_rr   [NC];
    int         m_t    [NC];
    logic [1:0] m_addr [NC];
    logic [1:0] m_din  [NC];
    logic [1:0] m_rd0  [NC];
    logic [1:0] m_rd1  [NC];
    logic [1:0] m_mem  [NC][4];

    task automatic chk(input string tag, input int k, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cfg%0d observed %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic model_cycle(input int k);
        bit e0, e1, xr0, xr1, xwr, xresp;
        if (rst) begin
            m_busy[k] = 0; m_rr[k] = 0; m_own[k] = 0; m_t[k] = 0;
            m_addr[k] = 0; m_din[k] = 0; m_rd0[k] = 0; m_rd1[k] = 0;
        end
        e0    = r0_valid;
        e1    = r1_valid & ~test_mode;
        xr0   = !m_busy[k] && e0 && (!e1 || m_rr[k]);
        xr1   = !m_busy[k] && e1 && (!e0 || !m_rr[k]);
        xwr   = m_busy[k] && m_wr[k] && m_t[k] >= 2 && m_t[k] <= 1 + WRC[k];
        xresp = m_busy[k] && !m_wr[k] && m_t[k] >= 1 + RDW[k];

        chk("r0_ready",  k, r0_ready_o[k],  xr0);
        chk("r1_ready",  k, r1_ready_o[k],  xr1);
        chk("r0_rvalid", k, r0_rvalid_o[k], xresp && !m_own[k]);
        chk("r1_rvalid", k, r1_rvalid_o[k], xresp && m_own[k]);
        chk("r0_rdata",  k, r0_rdata_o[k],  m_rd0[k]);
        chk("r1_rdata",  k, r1_rdata_o[k],  m_rd1[k]);
        chk("ram_wr",    k, ram_wr_o[k],    xwr);
        chk("ram_addr",  k, ram_addr_o[k],  m_addr[k]);
        chk("ram_din",   k, ram_din_o[k],   m_din[k]);
        chk("busy",      k, busy_o[k],      m_busy[k]);
        chk("grant_id",  k, grant_o[k],     m_own[k]);

        if (rst) return;
        if (m_busy[k]) begin
            if (m_wr[k]) begin
                if (xwr) m_mem[k][m_addr[k]] = m_din[k];
                if (m_t[k] == 1 + WRC[k]) m_busy[k] = 0;
                else m_t[k]++;
            end else begin
                if (m_t[k] == RDW[k]) begin
                    if (m_own[k]) m_rd1[k] = m_mem[k][m_addr[k]];
                    else          m_rd0[k] = m_mem[k][m_addr[k]];
                end
                if (m_t[k] >= 1 + RDW[k]) begin
                    if (m_own[k] ? r1_rready : r0_rready) m_busy[k] = 0;
                end else begin
                    m_t[k]++;
                end
            end
        end else if (xr0 || xr1) begin
            m_busy[k] = 1;
            m_t[k]    = 1;
            m_own[k]  = xr1;
            m_rr[k]   = xr1;
            m_wr[k]   = xr1 ? r1_we : r0_we;
            m_addr[k] = xr1 ? r1_addr : r0_addr;
            m_din[k]  = xr1 ? r1_wdata : r0_wdata;
        end
    endtask

    task automatic step();
        #1;
        for (int k = 0; k < NC; k++) model_cycle(k);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < NC; k++)
            for (int i = 0; i < 4; i++) m_mem[k][i] = 2'(i);
        rst = 1; test_mode = 0;
        r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_rready = 1;
        r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_rready = 1;
        run(2);
        rst = 0;
        step();

        // JTAG write addr 2 data 2'b10, then read it back
        r0_valid = 1; r0_we = 1; r0_addr = 2; r0_wdata = 2'b10;
        step();
        r0_valid = 0;
        run(8);
        r0_valid = 1; r0_we = 0;
        step();
        r0_valid = 0;
        run(8);
        for (int k = 0; k < NC; k++) chk("wr_rd_data", k, r0_rdata_o[k], 2'b10);

        // round-robin with both requesters reading continuously
        r0_valid = 1; r1_valid = 1; r0_we = 0; r1_we = 0;
        for (int i = 0; i < 30; i++) begin
            r0_addr = 2'($urandom_range(0, 3));
            r1_addr = 2'($urandom_range(0, 3));
            step();
        end

        // test-mode lock, then release
        test_mode = 1;
        run(20);
        test_mode = 0;
        run(10);

        // drain, then lock asserted while the host holds a read response
        r0_valid = 0; r1_valid = 0;
        run(10);
        r1_valid = 1; r1_we = 0; r1_addr = 1;
        step();
        r1_valid = 0; test_mode = 1; r0_valid = 1; r1_rready = 0;
        run(8);
        for (int k = 0; k < NC; k++) begin
            chk("hold_r1_rvalid", k, r1_rvalid_o[k], 1'b1);
            chk("hold_r0_ready",  k, r0_ready_o[k],  1'b0);
        end
        r1_rready = 1;
        run(6);
        test_mode = 0; r0_valid = 0;
        run(10);

        // async reset in the second write-pulse cycle of the WR_CYCLES=4 instance
        r1_valid = 1; r1_we = 1; r1_addr = 1; r1_wdata = 2'b11;
        step();
        r1_valid = 0;
        run(2);
        chk("pre_rst_wr", 1, ram_wr_o[1], 1'b1);
        rst = 1;
        #1;
        chk("async_wr",   1, ram_wr_o[1],    1'b0);
        chk("async_busy", 1, busy_o[1],      1'b0);
        chk("async_rv",   1, r1_rvalid_o[1], 1'b0);
        step();
        rst = 0;
        r0_valid = 1; r1_valid = 1; r0_we = 0; r1_we = 0;
        #1;
        for (int k = 0; k < NC; k++) begin
            chk("rst_tie_r1", k, r1_ready_o[k], 1'b1);
            chk("rst_tie_r0", k, r0_ready_o[k], 1'b0);
        end
        run(6);
        r0_valid = 0; r1_valid = 0;
        run(10);

        // back-to-back host write then read
        r1_valid = 1; r1_we = 1; r1_addr = 3; r1_wdata = 2'b01;
        step();
        r1_we = 0;
        run(12);
        r1_valid = 0;
        run(6);
        chk("param_rd", 2, r1_rdata_o[2], 2'b01);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            test_mode = ($urandom_range(0, 7) == 0);
            r0_valid  = 1'($urandom_range(0, 1));
            r0_we     = 1'($urandom_range(0, 1));
            r0_addr   = 2'($urandom_range(0, 3));
            r0_wdata  = 2'($urandom_range(0, 3));
            r0_rready = ($urandom_range(0, 3) != 0);
            r1_valid  = 1'($urandom_range(0, 1));
            r1_we     = 1'($urandom_range(0, 1));
            r1_addr   = 2'($urandom_range(0, 3));
            r1_wdata  = 2'($urandom_range(0, 3));
            r1_rready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
